// File: rtl/ddr3_bfm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_bfm_pkg
// Description : Shared DDR3 BFM types: burst order, burst lengths, log2 and
//               the flat-address to {bank,row,col} array index extractor.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_bfm_pkg;

    typedef enum logic {
        BO_SEQ = 1'b0,
        BO_IL  = 1'b1
    } burst_order_e;

    localparam int BL4 = 4;
    localparam int BL8 = 8;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Packs the configured bank/row/col fields of a flat address into
    // {bank, row, col}; all other address bits are dropped.
    function automatic logic [63:0] index(
        input logic [63:0] addr,
        input int          bank_lsb,
        input int          bank_bits,
        input int          row_lsb,
        input int          row_bits,
        input int          col_lsb,
        input int          col_bits
    );
        logic [63:0] bank;
        logic [63:0] row;
        logic [63:0] col;
        bank = (addr >> bank_lsb) & ((64'd1 << bank_bits) - 64'd1);
        row  = (addr >> row_lsb)  & ((64'd1 << row_bits)  - 64'd1);
        col  = (addr >> col_lsb)  & ((64'd1 << col_bits)  - 64'd1);
        return (bank << (row_bits + col_bits)) | (row << col_bits) | col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_burst_addr_gen
// Description : One burst channel: accepts a start, issues BURST_LEN beat
//               indices with sequential or interleaved column wrap, drives busy.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_burst_addr_gen
    import ddr3_bfm_pkg::*;
#(
    parameter int IDX_WIDTH = 26,
    parameter int BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 burst_il,
    input  logic [IDX_WIDTH-1:0] start_idx,
    output logic                 busy,
    output logic                 issue,
    output logic                 last,
    output logic                 err,
    output logic [IDX_WIDTH-1:0] beat_idx
);

    localparam int c_L = log2(BURST_LEN);

    logic                 r_busy;
    logic [c_L-1:0]       r_cnt;
    logic [IDX_WIDTH-1:0] r_base;
    burst_order_e         r_order;

    logic                 w_accept;
    logic [IDX_WIDTH-1:0] w_base;
    burst_order_e         w_order;
    logic [c_L-1:0]       w_off;
    logic [c_L-1:0]       w_c0;
    logic [c_L-1:0]       w_col;

    assign w_accept = start & ~r_busy;

    // Beat 0 goes out in the accept cycle straight from the inputs; later
    // beats come from the values captured at accept.
    assign w_base  = w_accept ? start_idx : r_base;
    assign w_order = w_accept ? burst_order_e'(burst_il) : r_order;
    assign w_off   = w_accept ? '0 : r_cnt;
    assign w_c0    = w_base[c_L-1:0];
    assign w_col   = (w_order == BO_IL) ? (w_c0 ^ w_off) : (w_c0 + w_off);

    assign beat_idx = {w_base[IDX_WIDTH-1:c_L], w_col};
    assign issue    = w_accept | r_busy;
    assign last     = r_busy && (r_cnt == c_L'(BURST_LEN - 1));
    assign err      = start & r_busy;
    assign busy     = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_base  <= '0;
            r_order <= BO_SEQ;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_cnt   <= c_L'(1);
            r_base  <= start_idx;
            r_order <= burst_order_e'(burst_il);
        end else if (r_busy) begin
            r_cnt <= r_cnt + c_L'(1);
            if (last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_burst_ram.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_burst_ram
// Description : Byte-masked DDR3 BFM storage array with independent BL4/BL8
//               read and write burst channels and an RD_LAT read pipe.
//               Define DDR3_RAM_WRFWD_EN to forward same-cycle write data to
//               a colliding read; otherwise the read sees pre-write data.
//               cmd_err is registered: it pulses the cycle after a dropped start.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_burst_ram
    import ddr3_bfm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 36,
    parameter int BANK_LSB   = 32,
    parameter int BANK_BITS  = 3,
    parameter int ROW_LSB    = 16,
    parameter int ROW_BITS   = 13,
    parameter int COL_LSB    = 0,
    parameter int COL_BITS   = 10,
    parameter int BURST_LEN  = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    burst_il,
    input  logic                    wr_start,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_dm,
    output logic                    wr_busy,
    input  logic                    rd_start,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_busy,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    cmd_err
);

    localparam int c_DM_WIDTH = DATA_WIDTH / 8;
    localparam int c_IW       = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int c_DEPTH    = 2 ** c_IW;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [c_IW-1:0]       w_wr_start_idx;
    logic [c_IW-1:0]       w_rd_start_idx;
    logic [c_IW-1:0]       w_wr_idx;
    logic [c_IW-1:0]       w_rd_idx;
    logic                  w_wr_issue;
    logic                  w_rd_issue;
    logic                  w_wr_err;
    logic                  w_rd_err;
    logic                  w_rd_last;
    logic                  w_unused_wr_last;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_pdata [RD_LAT];
    logic [RD_LAT-1:0]     r_pvalid;
    logic [RD_LAT-1:0]     r_plast;
    logic                  r_cmd_err;

    assign w_wr_start_idx = c_IW'(index(64'(wr_addr), BANK_LSB, BANK_BITS,
                                        ROW_LSB, ROW_BITS, COL_LSB, COL_BITS));
    assign w_rd_start_idx = c_IW'(index(64'(rd_addr), BANK_LSB, BANK_BITS,
                                        ROW_LSB, ROW_BITS, COL_LSB, COL_BITS));

    ddr3_burst_addr_gen #(
        .IDX_WIDTH (c_IW),
        .BURST_LEN (BURST_LEN)
    ) u_wr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (wr_start),
        .burst_il  (burst_il),
        .start_idx (w_wr_start_idx),
        .busy      (wr_busy),
        .issue     (w_wr_issue),
        .last      (w_unused_wr_last),
        .err       (w_wr_err),
        .beat_idx  (w_wr_idx)
    );

    ddr3_burst_addr_gen #(
        .IDX_WIDTH (c_IW),
        .BURST_LEN (BURST_LEN)
    ) u_rd_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (rd_start),
        .burst_il  (burst_il),
        .start_idx (w_rd_start_idx),
        .busy      (rd_busy),
        .issue     (w_rd_issue),
        .last      (w_rd_last),
        .err       (w_rd_err),
        .beat_idx  (w_rd_idx)
    );

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_wr_issue) begin
            for (int b = 0; b < c_DM_WIDTH; b++) begin
                if (!wr_dm[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

`ifdef DDR3_RAM_WRFWD_EN
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_issue && w_rd_issue && (w_wr_idx == w_rd_idx)) begin
            for (int b = 0; b < c_DM_WIDTH; b++) begin
                if (!wr_dm[b]) begin
                    w_rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end
`else
    assign w_rd_word = r_mem[w_rd_idx];
`endif

    // Stage 0 captures the issued beat; stage RD_LAT-1 drives the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pvalid <= '0;
            r_plast  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pdata[i] <= '0;
            end
        end else begin
            r_pvalid[0] <= w_rd_issue;
            r_plast[0]  <= w_rd_last;
            r_pdata[0]  <= w_rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pvalid[i] <= r_pvalid[i-1];
                r_plast[i]  <= r_plast[i-1];
                r_pdata[i]  <= r_pdata[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_wr_err | w_rd_err;
        end
    end

    assign rd_data  = r_pdata[RD_LAT-1];
    assign rd_valid = r_pvalid[RD_LAT-1];
    assign rd_last  = r_plast[RD_LAT-1];
    assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_burst_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_burst_ram
// Description : Directed scoreboard bench for ddr3_burst_ram (32-bit beats,
//               small address map, BL8, RD_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_burst_ram;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        burst_il;
    logic        wr_start;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_dm;
    logic        wr_busy;
    logic        rd_start;
    logic [15:0] rd_addr;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        cmd_err;

    always #5 clk = ~clk;

    ddr3_burst_ram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .BANK_LSB   (13),
        .BANK_BITS  (2),
        .ROW_LSB    (8),
        .ROW_BITS   (3),
        .COL_LSB    (0),
        .COL_BITS   (5),
        .BURST_LEN  (8),
        .RD_LAT     (RL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .burst_il (burst_il),
        .wr_start (wr_start),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_dm    (wr_dm),
        .wr_busy  (wr_busy),
        .rd_start (rd_start),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .cmd_err  (cmd_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [1024];
    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          cerr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Array index of beat i for a burst starting at flat address a.
    function automatic int tidx(input logic [15:0] a, input int i, input logic il);
        logic [2:0] lo;
        if (il) lo = a[2:0] ^ 3'(i);
        else    lo = 3'((int'(a[2:0]) + i) % 8);
        return int'({a[14:13], a[10:8], a[4:3], lo});
    endfunction

    task automatic mwrite(input int idx, input logic [31:0] d, input logic [3:0] dm);
        for (int b = 0; b < 4; b++) begin
            if (!dm[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic push_rd(input int idx, input logic [31:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        e.cyc  = cyc + RL;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cmd_err === 1'b1) cerr_seen++;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk1("rd_valid", rd_valid, 1'b1);
            chk("rd_data", rd_data, e.data);
            chk1("rd_last", rd_last, e.last);
        end else if (rd_valid !== 1'b0) begin
            chk1("rd_valid_spurious", rd_valid, 1'b0);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 12 && q.size() > 0; n++) tick();
        chk("rd_drain_left", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic wr_burst(input logic [15:0] a, input logic il, input logic [31:0] d0,
                            input logic [31:0] step, input logic [3:0] dm);
        for (int i = 0; i < 8; i++) begin
            wr_start = (i == 0);
            wr_addr  = a;
            burst_il = il;
            wr_data  = d0 + step * 32'(i);
            wr_dm    = dm;
            mwrite(tidx(a, i, il), wr_data, dm);
            tick();
            chk1("wr_busy", wr_busy, (i < 7));
        end
        wr_start = 1'b0;
    endtask

    task automatic rd_beats(input logic [15:0] a, input logic il);
        for (int i = 0; i < 8; i++) begin
            rd_start = (i == 0);
            rd_addr  = a;
            burst_il = il;
            push_rd(tidx(a, i, il), model[tidx(a, i, il)], (i == 7));
            tick();
            chk1("rd_busy", rd_busy, (i < 7));
        end
        rd_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        burst_il = 1'b0;
        wr_start = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_dm    = '0;
        rd_start = 1'b0;
        rd_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_wr_busy", wr_busy, 1'b0);
        chk1("rst_rd_busy", rd_busy, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk1("rst_rd_last", rd_last, 1'b0);
        chk1("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_rd_data", rd_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // BL8 sequential write at col 5, read back through an alias with ignored bits set.
        wr_burst(16'h2305, 1'b0, 32'h10, 32'd1, 4'h0);
        rd_beats(16'hA325, 1'b0);
        drain();
        // Interleaved read at col 6 exposes the write column order.
        rd_beats(16'h2306, 1'b1);
        drain();

        // Byte mask: DM=1 keeps the old byte.
        wr_burst(16'h4108, 1'b0, 32'hAABBCCDD, 32'd0, 4'h0);
        wr_burst(16'h4108, 1'b0, 32'h11223344, 32'd0, 4'b0101);
        rd_beats(16'h4108, 1'b0);
        drain();

        // Back-to-back gapless reads.
        cerr_seen = 0;
        rd_beats(16'h2305, 1'b0);
        rd_beats(16'h4108, 1'b0);
        drain();
        chk("b2b_cmd_err", 32'(cerr_seen), 32'd0);

        // Start while busy: dropped, single cmd_err pulse, burst intact.
        cerr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rd_start = (i == 0) || (i == 3);
            rd_addr  = (i == 3) ? 16'h2305 : 16'h4108;
            burst_il = 1'b0;
            push_rd(tidx(16'h4108, i, 1'b0), model[tidx(16'h4108, i, 1'b0)], (i == 7));
            tick();
        end
        rd_start = 1'b0;
        drain();
        chk("busy_start_cmd_err", 32'(cerr_seen), 32'd1);

        // Same-index read/write collision.
        wr_burst(16'h6710, 1'b0, 32'h55555555, 32'd0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            wr_start = (i == 0);
            rd_start = (i == 0);
            wr_addr  = 16'h6710;
            rd_addr  = 16'h6710;
            burst_il = 1'b0;
            wr_data  = 32'hA5A5A5A5;
            wr_dm    = 4'h0;
`ifdef DDR3_RAM_WRFWD_EN
            push_rd(tidx(16'h6710, i, 1'b0), 32'hA5A5A5A5, (i == 7));
`else
            push_rd(tidx(16'h6710, i, 1'b0), 32'h55555555, (i == 7));
`endif
            mwrite(tidx(16'h6710, i, 1'b0), wr_data, 4'h0);
            tick();
        end
        wr_start = 1'b0;
        rd_start = 1'b0;
        drain();
        rd_beats(16'h6710, 1'b0);
        drain();

        // Reset at beat 4 of an interleaved BL8 write with a read in flight.
        wr_burst(16'h0018, 1'b0, 32'h50000000, 32'd1, 4'h0);
        for (int i = 0; i < 4; i++) begin
            wr_start = (i == 0);
            rd_start = (i == 0);
            wr_addr  = 16'h001A;
            rd_addr  = 16'h2305;
            burst_il = 1'b1;
            wr_data  = 32'h60000000 + 32'(i);
            wr_dm    = 4'h0;
            mwrite(tidx(16'h001A, i, 1'b1), wr_data, 4'h0);
            push_rd(tidx(16'h2305, i, 1'b1), model[tidx(16'h2305, i, 1'b1)], 1'b0);
            tick();
        end
        wr_start = 1'b0;
        rd_start = 1'b0;
        wr_data  = 32'h60000004;
        reset_n  = 1'b0;
        #1;
        chk1("mid_rst_wr_busy", wr_busy, 1'b0);
        chk1("mid_rst_rd_busy", rd_busy, 1'b0);
        chk1("mid_rst_rd_valid", rd_valid, 1'b0);
        chk1("mid_rst_rd_last", rd_last, 1'b0);
        chk("mid_rst_rd_data", rd_data, 32'd0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rd_beats(16'h0018, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
